// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready request port and a held result port.
// Single-cycle ops for everything except divide. Define ALU_SEQ_DIV_EN to build
// the bit-serial restoring divider for op 3; without it op 3 reports err with a
// zero result after one cycle.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic             div_start;
    logic             div_last;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH+1:0] alu_res;

    // Single-cycle result: {err, carry, result}
    function automatic logic [WIDTH+1:0] alu_f(input logic [3:0] f_op,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        logic [WIDTH:0]   wide;
        logic [W2-1:0]    prod;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             e;
        wide = '0;
        prod = '0;
        r    = '0;
        c    = 1'b0;
        e    = 1'b0;
        case (f_op)
            4'h0: begin
                wide = {1'b0, x} + {1'b0, y};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
            end
            4'h1: begin
                wide = {1'b0, x} - {1'b0, y};
                r    = wide[WIDTH-1:0];
                c    = wide[WIDTH];
            end
            4'h2: begin
                prod = W2'(x) * W2'(y);
                r    = prod[WIDTH-1:0];
                c    = |prod[W2-1:WIDTH];
            end
            4'h3: begin
`ifdef ALU_SEQ_DIV_EN
                // Only reached for a zero divisor; nonzero divisors go iterative.
                r = '1;
`else
                r = '0;
`endif
                e = 1'b1;
            end
            4'h4: begin
                r = {x[WIDTH-2:0], 1'b0};
                c = x[WIDTH-1];
            end
            4'h5: begin
                r = {1'b0, x[WIDTH-1:1]};
                c = x[0];
            end
            4'h6: begin
                r = {x[WIDTH-2:0], x[WIDTH-1]};
                c = x[WIDTH-1];
            end
            4'h7: begin
                r = {x[0], x[WIDTH-1:1]};
                c = x[0];
            end
            4'h8: r = x & y;
            4'h9: r = x | y;
            4'hA: r = x ^ y;
            4'hB: r = ~(x | y);
            4'hC: r = ~(x & y);
            4'hD: r = ~(x ^ y);
            4'hE: r = {{(WIDTH-1){1'b0}}, (x > y)};
            default: r = {{(WIDTH-1){1'b0}}, (x == y)};
        endcase
        return {e, c, r};
    endfunction

    assign alu_res = alu_f(op, a, b);

`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    assign div_start = (op == 4'h3) && (b != '0);

    // One restoring-division step: shift in the next dividend bit, try subtract
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign q_bit    = ~diff[WIDTH];
    assign rem_step = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], q_bit};
    assign div_quo  = quo_step;
    assign div_last = (cnt_q == CW'(1));

    // Divider load on acceptance, then one quotient bit per BUSY cycle
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (state_q == S_IDLE && in_valid && div_start) begin
            rem_d = '0;
            quo_d = a;
            dvs_d = b;
            cnt_d = CW'(WIDTH);
        end else if (state_q == S_BUSY) begin
            rem_d = rem_step;
            quo_d = quo_step;
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Divider registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end
`else
    assign div_start = 1'b0;
    assign div_last  = 1'b1;
    assign div_quo   = '0;
`endif

    // Next state and result capture
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (div_start) begin
                        state_d = S_BUSY;
                    end else begin
                        err_d    = alu_res[WIDTH+1];
                        carry_d  = alu_res[WIDTH];
                        result_d = alu_res[WIDTH-1:0];
                        zero_d   = (alu_res[WIDTH-1:0] == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                if (div_last) begin
                    result_d = div_quo;
                    carry_d  = 1'b0;
                    err_d    = 1'b0;
                    zero_d   = (div_quo == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    // Ready is gated by reset so it reads 0 while reset is held
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vectors plus random ops against an arithmetic reference.
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         err;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: result, carry, err and latency in cycles from plain arithmetic.
    function automatic void ref_op(input int unsigned o, input longint unsigned x,
                                   input longint unsigned y, output longint unsigned r,
                                   output bit c, output bit e, output int lat);
        longint unsigned m;
        longint unsigned full;
        m   = (64'd1 << W) - 1;
        r   = 0;
        c   = 0;
        e   = 0;
        lat = 1;
        case (o)
            0:  begin full = x + y; r = full & m; c = (full >> W) != 0; end
            1:  begin r = (x - y) & m; c = (x < y); end
            2:  begin full = x * y; r = full & m; c = (full >> W) != 0; end
            3:  begin
`ifdef ALU_SEQ_DIV_EN
                if (y == 0) begin r = m; e = 1; end
                else begin r = x / y; lat = W + 1; end
`else
                r = 0; e = 1;
`endif
            end
            4:  begin r = (x << 1) & m; c = ((x >> (W - 1)) & 1) != 0; end
            5:  begin r = x >> 1; c = (x & 1) != 0; end
            6:  begin r = ((x << 1) | (x >> (W - 1))) & m; c = ((x >> (W - 1)) & 1) != 0; end
            7:  begin r = (x >> 1) | ((x & 1) << (W - 1)); c = (x & 1) != 0; end
            8:  r = x & y;
            9:  r = x | y;
            10: r = x ^ y;
            11: r = ~(x | y) & m;
            12: r = ~(x & y) & m;
            13: r = ~(x ^ y) & m;
            14: r = (x > y) ? 1 : 0;
            default: r = (x == y) ? 1 : 0;
        endcase
    endfunction

    task automatic junk_inputs();
        in_valid = 1'($urandom);
        a        = W'($urandom);
        b        = W'($urandom);
        op       = 4'($urandom);
    endtask

    // One full transaction; hold = cycles out_ready stays low once out_valid is seen.
    task automatic do_op(input int unsigned o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int hold);
        longint unsigned er;
        bit ec;
        bit ee;
        int lat;
        int cyc;
        ref_op(o, longint'(x), longint'(y), er, ec, ee, lat);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        a         = x;
        b         = y;
        op        = 4'(o);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < int'(W) + 4) begin
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            junk_inputs();
            @(posedge clk); #1;
            cyc++;
        end
        chk($sformatf("latency_op%0d", o), 64'(cyc), 64'(lat));
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_result", 64'(result), 64'(er));
            chk("hold_carry", 64'(carry), 64'(ec));
            chk("hold_zero", 64'(zero), 64'(er == 0));
            chk("hold_err", 64'(err), 64'(ee));
            junk_inputs();
            @(posedge clk); #1;
        end
        chk($sformatf("result_op%0d_%0h_%0h", o, x, y), 64'(result), 64'(er));
        chk($sformatf("carry_op%0d_%0h_%0h", o, x, y), 64'(carry), 64'(ec));
        chk($sformatf("zero_op%0d_%0h_%0h", o, x, y), 64'(zero), 64'(er == 0));
        chk($sformatf("err_op%0d_%0h_%0h", o, x, y), 64'(err), 64'(ee));
        chk("out_valid_done", 64'(out_valid), 64'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_clear", 64'(out_valid), 64'd0);
        chk("in_ready_return", 64'(in_ready), 64'd1);
    endtask

    int unsigned d_op[16]   = '{0,    0,    1,    3,    3,    2,    3,    3,    3,    4,    5,    6,    7,    14,   15,   11};
    int unsigned d_a[16]    = '{'h0A, 'hF6, 'h02, 'hF6, 'h10, 'h20, 'h0A, 'hFF, 'h05, 'h80, 'h01, 'h81, 'h81, 'h05, 'h05, 'hFF};
    int unsigned d_b[16]    = '{'h02, 'h0A, 'h03, 'h0A, 'h00, 'h10, 'h02, 'h01, 'h07, 'h00, 'h00, 'h00, 'h00, 'h05, 'h05, 'h00};
    int          d_hold[16] = '{0,    0,    0,    0,    0,    5,    0,    0,    0,    1,    0,    2,    0,    0,    0,    0};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'({carry, zero, err}), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 16; i++) begin
            do_op(d_op[i], W'(d_a[i]), W'(d_b[i]), d_hold[i]);
        end

        // Reset three cycles into a divide aborts it
        a        = W'(8'hF6);
        b        = W'(8'h0A);
        op       = 4'h3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_flags", 64'({carry, zero, err}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("abort_no_result", 64'(out_valid), 64'd0);
        do_op(0, W'(8'h0A), W'(8'h02), 0);

        // Random traffic, occasionally with a zero divisor
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            do_op($urandom_range(0, 15), ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1, operation request.
REQ-005 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, operands (unsigned).
REQ-007 The block SHALL have port op, input, 4, opcode: 0 add, 1 sub, 2 mul, 3 div, 4 shl, 5 shr, 6 rol, 7 ror, 8 and, 9 or, A xor, B nor, C nand, D xnor, E a>b, F a==b.
REQ-008 The block SHALL have port out_valid, output, 1, result available.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port result, output, WIDTH, operation result.
REQ-011 The block SHALL have port carry, output, 1, carry/borrow/shift-out flag.
REQ-012 The block SHALL have port zero, output, 1, high when result equals 0.
REQ-013 The block SHALL have port err, output, 1, high on divide-by-zero or an unsupported op.

Function
REQ-014 The FSM SHALL have states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE.
REQ-015 On in_valid&&in_ready, a, b and op SHALL be captured; the FSM goes to BUSY for op 3 with b!=0, otherwise to DONE.
REQ-016 Non-divide ops SHALL have 1-cycle latency: out_valid rises on the edge after acceptance.
REQ-017 Divide SHALL use a restoring divider producing one quotient bit per cycle, entering DONE exactly WIDTH+1 cycles after acceptance.
REQ-018 In DONE, out_valid SHALL be 1 and result/carry/zero/err SHALL hold stable until out_ready=1; that edge returns the FSM to IDLE and clears out_valid.
REQ-019 Inputs SHALL be ignored in BUSY and DONE, and in_valid, a, b and op changes there SHALL have no effect.
REQ-020 Add/sub SHALL wrap modulo 2^WIDTH; carry SHALL be the add carry-out, or the sub borrow (1 when a<b).
REQ-021 Mul SHALL return the low WIDTH bits of a*b; carry SHALL be 1 when any of the upper WIDTH bits is nonzero.
REQ-022 Div SHALL return floor(a/b); carry SHALL be 0.
REQ-023 For div with b==0, result SHALL be all-ones, err SHALL be 1, and latency SHALL be 1.
REQ-024 shl/shr SHALL shift by one with zero fill; carry SHALL be the bit shifted out (a[WIDTH-1] or a[0]).
REQ-025 rol/ror SHALL rotate by one; carry SHALL be the bit that wrapped.
REQ-026 Logic ops SHALL set carry to 0.
REQ-027 Compare ops SHALL return 1 or 0 zero-extended to WIDTH; carry SHALL be 0.
REQ-028 zero SHALL be computed from the final result for every op.

Reset
REQ-029 While rst=1, the state SHALL be IDLE, and in_ready SHALL be 0 and out_valid 0.
REQ-030 While rst=1, result, carry, zero and err SHALL be 0.
REQ-031 After rst falls, in_ready SHALL be 1 from the first cycle.
REQ-032 Reset during BUSY or DONE SHALL abort the operation with no result emitted.

Configuration
REQ-033 With macro ALU_SEQ_DIV_EN defined, op 3 SHALL use the iterative divider per REQ-017/REQ-022/REQ-023.
REQ-034 Without ALU_SEQ_DIV_EN, no divider logic SHALL be built, and op 3 SHALL complete in 1 cycle with result 0, carry 0, zero 1 and err 1.

Verification
REQ-035 Reset, then add, WIDTH=8, a=0x0A, b=0x02, out_ready=1 -> out_valid 1 cycle later, result 0x0C, carry 0, zero 0, err 0.
REQ-036 Add a=0xF6, b=0x0A -> result 0x00, carry 1, zero 1; then sub a=0x02, b=0x03 -> result 0xFF, carry 1.
REQ-037 Div a=0xF6, b=0x0A with DIV_EN -> in_ready 0 for 9 cycles, result 0x18, err 0; div a=0x10, b=0 -> result 0xFF, err 1 after 1 cycle.
REQ-038 Hold out_ready=0 for 5 cycles after a mul a=0x20, b=0x10 -> result 0x00, carry 1, zero 1 stable throughout; in_valid pulses in that window are ignored.
REQ-039 Assert rst 3 cycles into a div -> all outputs 0 immediately; after release, a new add completes normally.
REQ-040 Build without ALU_SEQ_DIV_EN, div a=0x0A, b=0x02 -> 1-cycle latency, result 0x00, zero 1, err 1.
